debounce_scheduler: RTL and testbench

- Multi-channel button front end for the user-input path.
- Synchronises and debounces N_CH noisy inputs using one shared sample-tick prescaler in place of a wide counter per channel.
- Turns each committed level change into a press/release event.
- A round-robin arbiter serialises these events onto a single valid/ready port consumed by the game/control FSMs.

---
 rtl/debounce_scheduler.sv | 141 ++++++++++++++
 tb/tb_debounce_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/debounce_scheduler.sv
// Multi-channel switch debouncer sharing one sample-tick prescaler, with a round-robin
// arbiter that serialises committed press/release events onto a single valid/ready port.
module debounce_scheduler #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned TICK_DIV     = 2500,
  parameter int unsigned STABLE_TICKS = 100,
  parameter int unsigned CH_W         = $clog2(N_CH)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_CH-1:0] noisy,
  output logic [N_CH-1:0] clean,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CH_W-1:0] evt_ch,
  output logic            evt_rise,
  output logic [N_CH-1:0] pending,
  output logic            overrun,
  input  logic            overrun_clr
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = $clog2(STABLE_TICKS);
  localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CntMax   = CW'(STABLE_TICKS - 1);

  logic [N_CH-1:0]         sync1_q, sync2_q;
  logic [PW-1:0]           presc_q, presc_d;
  logic [N_CH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]         clean_q, clean_d;
  logic [N_CH-1:0]         dir_q, dir_d;
  logic [N_CH-1:0]         pend_q, pend_d;
  logic                    evt_valid_q, evt_valid_d;
  logic [CH_W-1:0]         evt_ch_q, evt_ch_d;
  logic                    evt_rise_q, evt_rise_d;
  logic                    overrun_q, overrun_d;
  logic [CH_W-1:0]         rr_q, rr_d;

  logic            tick;
  logic            found;
  logic [CH_W-1:0] grant;
  logic            can_load;
  logic            load;
  logic            ovr_set;
  int unsigned     idx;

  always_comb begin
    // First pending channel at or above rr_q, wrapping modulo N_CH.
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int unsigned off = 0; off < N_CH; off++) begin
      idx = 32'(rr_q) + off;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!found && pend_q[CH_W'(idx)]) begin
        found = 1'b1;
        grant = CH_W'(idx);
      end
    end

    tick     = (presc_q == PrescMax);
    presc_d  = tick ? '0 : presc_q + 1'b1;
    can_load = !evt_valid_q || evt_ready;
    load     = can_load && found;

    cnt_d       = cnt_q;
    clean_d     = clean_q;
    dir_d       = dir_q;
    pend_d      = pend_q;
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    evt_rise_d  = evt_rise_q;
    rr_d        = rr_q;
    ovr_set     = 1'b0;

    if (can_load) evt_valid_d = found;
    if (load) begin
      evt_ch_d     = grant;
      evt_rise_d   = dir_q[grant];
      pend_d[grant] = 1'b0;
      rr_d         = (32'(grant) == N_CH - 1) ? '0 : grant + 1'b1;
    end

    // Commits are applied after the grant so a same-cycle commit keeps pending set.
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (sync2_q[i] == clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CntMax) begin
          clean_d[i] = sync2_q[i];
          dir_d[i]   = sync2_q[i];
          cnt_d[i]   = '0;
          pend_d[i]  = 1'b1;
          if (pend_q[i] && !(load && grant == CH_W'(i))) ovr_set = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end

    overrun_d = ovr_set ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      presc_q     <= '0;
      cnt_q       <= '0;
      clean_q     <= '0;
      dir_q       <= '0;
      pend_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_rise_q  <= 1'b0;
      overrun_q   <= 1'b0;
      rr_q        <= '0;
    end else begin
      sync1_q     <= noisy;
      sync2_q     <= sync1_q;
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      clean_q     <= clean_d;
      dir_q       <= dir_d;
      pend_q      <= pend_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      evt_rise_q  <= evt_rise_d;
      overrun_q   <= overrun_d;
      rr_q        <= rr_d;
    end
  end

  assign clean     = clean_q;
  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;
  assign evt_rise  = evt_rise_q;
  assign pending   = pend_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler with TICK_DIV=4, STABLE_TICKS=3, N_CH=4.
module tb_debounce_scheduler;

  logic       clock;
  logic       reset;
  logic [3:0] noisy;
  logic [3:0] clean;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_ch;
  logic       evt_rise;
  logic [3:0] pending;
  logic       overrun;
  logic       overrun_clr;

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0] evq[$];
  logic [1:0] seen;

  debounce_scheduler #(
    .N_CH        (4),
    .TICK_DIV    (4),
    .STABLE_TICKS(3)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .noisy      (noisy),
    .clean      (clean),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_ch     (evt_ch),
    .evt_rise   (evt_rise),
    .pending    (pending),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Record each accepted event as {ch, rise}; the handshake completes at the next posedge.
  always @(negedge clock) begin
    if (!reset && evt_valid && evt_ready) evq.push_back({evt_ch, evt_rise});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ev(input int i);
    if (i < evq.size()) return 32'(evq[i]);
    return 32'hEEEE;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Leaves reset released just after a posedge, so edge n later has prescaler = n mod 4.
  task automatic do_reset(input logic [3:0] nz);
    reset = 1'b1;
    step();
    step();
    evq.delete();
    reset = 1'b0;
    noisy = nz;
  endtask

  initial begin
    reset       = 1'b1;
    noisy       = 4'hF;
    evt_ready   = 1'b1;
    overrun_clr = 1'b0;

    // 1. Reset and power-up presses
    #1;
    check("rst_t0", 32'({clean, evt_valid, pending, overrun, evt_ch, evt_rise}), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_hold", 32'({clean, evt_valid, pending, overrun, evt_ch, evt_rise}), 32'h0);
    end
    reset = 1'b0;
    repeat (11) step();
    check("t1_clean_e11", 32'(clean), 32'h0);
    step();
    check("t1_clean_e12", 32'(clean), 32'hF);
    step();
    check("t1_first_valid", 32'({evt_valid, evt_ch}), 32'({1'b1, 2'd0}));
    repeat (6) step();
    check("t1_nev", 32'(evq.size()), 32'd4);
    check("t1_ev0", ev(0), 32'h1);
    check("t1_ev1", ev(1), 32'h3);
    check("t1_ev2", ev(2), 32'h5);
    check("t1_ev3", ev(3), 32'h7);
    check("t1_idle", 32'(evt_valid), 32'h0);

    // 2. Single press on ch1
    do_reset(4'b0010);
    repeat (11) step();
    check("t2_clean_e11", 32'(clean), 32'h0);
    step();
    check("t2_clean_e12", 32'(clean), 32'h2);
    check("t2_valid_e12", 32'(evt_valid), 32'h0);
    step();
    check("t2_evt_e13", 32'({evt_valid, evt_ch, evt_rise}), 32'({1'b1, 2'd1, 1'b1}));
    step();
    check("t2_valid_e14", 32'(evt_valid), 32'h0);
    repeat (5) step();
    check("t2_nev", 32'(evq.size()), 32'd1);
    check("t2_ev0", ev(0), 32'h3);

    // 3. Bounce on ch0, then settle high
    do_reset(4'b0001);
    seen = 2'b00;
    for (int n = 1; n <= 60; n++) begin
      step();
      seen = seen | {clean[0], evt_valid};
      if (n % 5 == 0) noisy[0] = ~noisy[0];
    end
    check("t3_bounce_quiet", 32'(seen), 32'h0);
    check("t3_bounce_nev", 32'(evq.size()), 32'd0);
    repeat (11) step();
    check("t3_clean_e71", 32'(clean), 32'h0);
    step();
    check("t3_clean_e72", 32'(clean), 32'h1);
    repeat (3) step();
    check("t3_nev", 32'(evq.size()), 32'd1);
    check("t3_ev0", ev(0), 32'h1);

    // 4. Arbitration order
    evt_ready = 1'b0;
    do_reset(4'b1010);
    repeat (12) step();
    check("t4_pend_e12", 32'(pending), 32'hA);
    step();
    check("t4_evt_e13", 32'({evt_valid, evt_ch, pending}), 32'({1'b1, 2'd1, 4'b1000}));
    repeat (3) step();
    check("t4_hold", 32'({evt_valid, evt_ch, evt_rise}), 32'({1'b1, 2'd1, 1'b1}));
    evt_ready = 1'b1;
    repeat (4) step();
    check("t4_nev_a", 32'(evq.size()), 32'd2);
    check("t4_ev0", ev(0), 32'h3);
    check("t4_ev1", ev(1), 32'h7);
    check("t4_idle", 32'(evt_valid), 32'h0);
    evq.delete();
    noisy = 4'hF;
    repeat (20) step();
    check("t4_nev_b", 32'(evq.size()), 32'd2);
    check("t4_ev2", ev(0), 32'h1);
    check("t4_ev3", ev(1), 32'h5);

    // 5. Overrun: ch0 occupies the output while ch2 presses then releases
    evt_ready = 1'b0;
    do_reset(4'b0001);
    repeat (13) step();
    check("t5_busy", 32'({evt_valid, evt_ch}), 32'({1'b1, 2'd0}));
    noisy = 4'b0101;
    repeat (11) step();
    check("t5_pend_press", 32'({pending, overrun}), 32'({4'b0100, 1'b0}));
    noisy = 4'b0001;
    repeat (11) step();
    check("t5_ovr_e35", 32'(overrun), 32'h0);
    step();
    check("t5_ovr_e36", 32'({pending, overrun}), 32'({4'b0100, 1'b1}));
    evt_ready = 1'b1;
    repeat (4) step();
    check("t5_nev", 32'(evq.size()), 32'd2);
    check("t5_ev0", ev(0), 32'h1);
    check("t5_ev1", ev(1), 32'h4);
    check("t5_ovr_sticky", 32'(overrun), 32'h1);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("t5_ovr_clr", 32'(overrun), 32'h0);

    // 6. Asynchronous reset mid-cycle with an event in flight
    evt_ready = 1'b0;
    do_reset(4'b0011);
    repeat (13) step();
    check("t6_pre", 32'({evt_valid, pending}), 32'({1'b1, 4'b0010}));
    #2;
    reset = 1'b1;
    #1;
    check("t6_async", 32'({evt_valid, pending, clean}), 32'h0);
    step();
    evq.delete();
    reset     = 1'b0;
    noisy     = 4'h0;
    evt_ready = 1'b1;
    repeat (20) step();
    check("t6_no_stale", 32'(evq.size()), 32'd0);
    check("t6_idle", 32'({evt_valid, pending}), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
